// File: rtl/arm_decode_unit.sv
// arm_decode_unit: instruction register, NZCV flags and valid bit feeding
// the microsequencer with a one-hot family vector and evaluated condition.
//
// Ports:
//   clk, rst           rising-edge clock, async active-high reset
//   ld_ir, ir_in       capture instruction word into IR (sets valid)
//   flush              invalidate IR; wins over a same-cycle ld_ir
//   flags_we, flags_in per-bit {N,Z,C,V} write enable and data
//   family_bits        one-hot instruction family, zero when invalid
//   COND               condition field passes against current flags
//   L, P, A            IR[20], IR[24], IR[21], zero when invalid
//   ir_out, flags_out  current IR and {N,Z,C,V}
//   ir_valid           IR holds a loaded, undispatched instruction
module arm_decode_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_ir,
    input  logic [31:0] ir_in,
    input  logic        flush,
    input  logic [3:0]  flags_we,
    input  logic [3:0]  flags_in,
    output logic [15:0] family_bits,
    output logic        COND,
    output logic        L,
    output logic        P,
    output logic        A,
    output logic [31:0] ir_out,
    output logic [3:0]  flags_out,
    output logic        ir_valid
);

    logic [31:0] ir;
    logic [3:0]  flags;
    logic        valid;
    logic        n, z, c, v;
    logic        cond_pass;
    logic        psr_bx, mul, swp;
    logic [15:0] family;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir    <= '0;
            flags <= '0;
            valid <= 1'b0;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (ld_ir) begin
                ir    <= ir_in;
                valid <= 1'b1;
            end
            flags <= (flags & ~flags_we) | (flags_in & flags_we);
        end
    end

    assign {n, z, c, v} = flags;

    always_comb begin
        cond_pass = 1'b0;
        unique case (ir[31:28])
            4'h0: cond_pass = z;
            4'h1: cond_pass = !z;
            4'h2: cond_pass = c;
            4'h3: cond_pass = !c;
            4'h4: cond_pass = n;
            4'h5: cond_pass = !n;
            4'h6: cond_pass = v;
            4'h7: cond_pass = !v;
            4'h8: cond_pass = c && !z;
            4'h9: cond_pass = !c || z;
            4'hA: cond_pass = (n == v);
            4'hB: cond_pass = (n != v);
            4'hC: cond_pass = !z && (n == v);
            4'hD: cond_pass = z || (n != v);
            4'hE: cond_pass = 1'b1;
            4'hF: cond_pass = 1'b0;
        endcase
    end

    // PSR/BX lives in both the 000 and 001 classes, so it is tested
    // before the class split; the 25=0,7=1,4=1 exclusion hands swap
    // and halfword encodings to their own families.
    assign psr_bx = (ir[27:26] == 2'b00) && (ir[24:23] == 2'b10)
                 && !ir[20] && !(!ir[25] && ir[7] && ir[4]);
    assign mul = (ir[27:24] == 4'b0000) && (ir[7:4] == 4'b1001);
    assign swp = (ir[27:23] == 5'b00010) && (ir[21:20] == 2'b00)
              && (ir[11:4] == 8'b0000_1001);

    always_comb begin
        family = '0;
        if (!valid) begin
            family = '0;
        end else if (psr_bx) begin
            family[5] = 1'b1;
        end else begin
            unique case (ir[27:25])
                3'b000: begin
                    if (mul)                family[2] = 1'b1;
                    else if (swp)           family[3] = 1'b1;
                    else if (ir[7] && ir[4]) family[4] = 1'b1;
                    else if (ir[4])         family[1] = 1'b1;
                    else                    family[0] = 1'b1;
                end
                3'b001: family[6] = 1'b1;
                3'b010: family[7] = 1'b1;
                3'b011: begin
                    if (ir[4]) family[9] = 1'b1;
                    else       family[8] = 1'b1;
                end
                3'b100: family[10] = 1'b1;
                3'b101: family[11] = 1'b1;
                3'b110: family[12] = 1'b1;
                3'b111: begin
                    if (ir[24])     family[15] = 1'b1;
                    else if (ir[4]) family[14] = 1'b1;
                    else            family[13] = 1'b1;
                end
            endcase
        end
    end

    assign family_bits = family;
    assign COND        = valid && cond_pass;
    assign L           = valid && ir[20];
    assign P           = valid && ir[24];
    assign A           = valid && ir[21];
    assign ir_out      = ir;
    assign flags_out   = flags;
    assign ir_valid    = valid;

endmodule

// File: tb/tb_arm_decode_unit.sv
// tb_arm_decode_unit: directed vectors with a bench-side reference model
// compared every falling edge, plus literal expectations.
module tb_arm_decode_unit;

    logic        clk;
    logic        rst;
    logic        ld_ir;
    logic [31:0] ir_in;
    logic        flush;
    logic [3:0]  flags_we;
    logic [3:0]  flags_in;
    logic [15:0] family_bits;
    logic        COND;
    logic        L;
    logic        P;
    logic        A;
    logic [31:0] ir_out;
    logic [3:0]  flags_out;
    logic        ir_valid;

    int checks = 0;
    int errors = 0;

    arm_decode_unit dut (
        .clk(clk), .rst(rst), .ld_ir(ld_ir), .ir_in(ir_in),
        .flush(flush), .flags_we(flags_we), .flags_in(flags_in),
        .family_bits(family_bits), .COND(COND), .L(L), .P(P), .A(A),
        .ir_out(ir_out), .flags_out(flags_out), .ir_valid(ir_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model state
    logic [31:0] m_ir;
    logic [3:0]  m_flags;
    logic        m_valid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ir = 0;
            m_flags = 0;
            m_valid = 0;
        end else begin
            if (flush) m_valid = 0;
            else if (ld_ir) begin
                m_ir = ir_in;
                m_valid = 1;
            end
            for (int i = 0; i < 4; i++)
                if (flags_we[i]) m_flags[i] = flags_in[i];
        end
    end

    // Conditions come in complementary pairs: even code is the base
    // test, odd code its inverse; AL/NV is the always pair.
    function automatic logic cond_model(input logic [3:0] code,
                                        input logic [3:0] f);
        logic fn, fz, fc, fv, base;
        {fn, fz, fc, fv} = f;
        case (code[3:1])
            3'd0: base = fz;
            3'd1: base = fc;
            3'd2: base = fn;
            3'd3: base = fv;
            3'd4: base = fc & ~fz;
            3'd5: base = (fn == fv);
            3'd6: base = ~fz & (fn == fv);
            default: base = 1'b1;
        endcase
        return code[0] ? ~base : base;
    endfunction

    function automatic int fam_model(input logic [31:0] w);
        if ((w ==? 32'b????_00?1_0??0_????_????_????_????_????) &&
            !(w ==? 32'b????_??0?_????_????_????_????_1??1_????))
            return 5;
        if (w ==? 32'b????_0000_????_????_????_????_1001_????) return 2;
        if (w ==? 32'b????_0001_0?00_????_????_0000_1001_????) return 3;
        if (w ==? 32'b????_000?_????_????_????_????_1??1_????) return 4;
        if (w ==? 32'b????_000?_????_????_????_????_0??1_????) return 1;
        if (w ==? 32'b????_000?_????_????_????_????_???0_????) return 0;
        if (w ==? 32'b????_001?_????_????_????_????_????_????) return 6;
        if (w ==? 32'b????_010?_????_????_????_????_????_????) return 7;
        if (w ==? 32'b????_011?_????_????_????_????_???0_????) return 8;
        if (w ==? 32'b????_011?_????_????_????_????_???1_????) return 9;
        if (w ==? 32'b????_100?_????_????_????_????_????_????) return 10;
        if (w ==? 32'b????_101?_????_????_????_????_????_????) return 11;
        if (w ==? 32'b????_110?_????_????_????_????_????_????) return 12;
        if (w ==? 32'b????_1110_????_????_????_????_???0_????) return 13;
        if (w ==? 32'b????_1110_????_????_????_????_???1_????) return 14;
        if (w ==? 32'b????_1111_????_????_????_????_????_????) return 15;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            int fi;
            logic [15:0] ef;
            fi = fam_model(m_ir);
            ef = (m_valid && fi >= 0) ? (16'd1 << fi) : 16'd0;
            chk("model_family", {16'd0, family_bits}, {16'd0, ef});
            chk("model_cond", {31'd0, COND},
                {31'd0, m_valid && cond_model(m_ir[31:28], m_flags)});
            chk("model_lpa", {29'd0, L, P, A},
                {29'd0, m_valid && m_ir[20], m_valid && m_ir[24],
                 m_valid && m_ir[21]});
            chk("model_ir", ir_out, m_ir);
            chk("model_flags", {28'd0, flags_out}, {28'd0, m_flags});
            chk("model_valid", {31'd0, ir_valid}, {31'd0, m_valid});
            if (ir_valid)
                chk("onehot", {31'd0, $onehot(family_bits)}, 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [31:0] w);
        ld_ir = 1'b1;
        ir_in = w;
        tick();
        ld_ir = 1'b0;
    endtask

    logic [31:0] sweep_w [11];
    int          sweep_f [11];

    initial begin
        sweep_w = '{32'hE0810002, 32'hE0010392, 32'hE1012093,
                    32'hE1D120B0, 32'hE10F0000, 32'hE12FFF11,
                    32'hE3A00001, 32'hE5912004, 32'hE8BD8000,
                    32'hEA000000, 32'hEF000000};
        sweep_f = '{0, 2, 3, 4, 5, 5, 6, 7, 10, 11, 15};

        rst = 1'b1;
        ld_ir = 1'b0;
        ir_in = '0;
        flush = 1'b0;
        flags_we = '0;
        flags_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_family", {16'd0, family_bits}, 32'd0);
        chk("rst_ir", ir_out, 32'd0);
        chk("rst_cond", {31'd0, COND}, 32'd0);

        // Load plus flag write, then async reset between edges
        flags_we = 4'hF;
        flags_in = 4'b1010;
        load(32'hE0810002);
        flags_we = 4'h0;
        chk("pre_rst_family", {16'd0, family_bits}, 32'h0001);
        chk("pre_rst_cond", {31'd0, COND}, 32'd1);
        chk("pre_rst_flags", {28'd0, flags_out}, 32'hA);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, ir_valid}, 32'd0);
        chk("mid_rst_family", {16'd0, family_bits}, 32'd0);
        chk("mid_rst_cond", {31'd0, COND}, 32'd0);
        chk("mid_rst_flags", {28'd0, flags_out}, 32'd0);
        chk("mid_rst_ir", ir_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Decode sweep
        for (int i = 0; i < 11; i++) begin
            load(sweep_w[i]);
            chk("sweep_family", {16'd0, family_bits},
                32'd1 << sweep_f[i]);
            if (sweep_w[i] == 32'hE5912004)
                chk("sweep_lpa", {29'd0, L, P, A}, 32'b110);
        end
        tick();
        chk("hold_valid", {31'd0, ir_valid}, 32'd1);
        chk("hold_ir", ir_out, 32'hEF000000);

        // Conditions with only Z set
        flags_we = 4'hF;
        flags_in = 4'b0100;
        tick();
        flags_we = 4'h0;
        load(32'h00000000);
        chk("cond_eq", {31'd0, COND}, 32'd1);
        load(32'h10000000);
        chk("cond_ne", {31'd0, COND}, 32'd0);
        load(32'hD0000000);
        chk("cond_le", {31'd0, COND}, 32'd1);
        load(32'hC0000000);
        chk("cond_gt", {31'd0, COND}, 32'd0);
        load(32'hF0000000);
        chk("cond_nv", {31'd0, COND}, 32'd0);
        flags_we = 4'b0010;
        flags_in = 4'b0010;
        tick();
        flags_we = 4'h0;
        chk("flags_czset", {28'd0, flags_out}, 32'b0110);
        load(32'h80000000);
        chk("cond_hi", {31'd0, COND}, 32'd0);

        // Same-edge load and flag write
        flags_we = 4'hF;
        flags_in = 4'h0;
        tick();
        flags_we = 4'b0100;
        flags_in = 4'b0100;
        load(32'h00000000);
        flags_we = 4'h0;
        chk("same_edge_cond", {31'd0, COND}, 32'd1);

        // Same-edge flush and load
        load(32'hEA000000);
        flush = 1'b1;
        load(32'hE3A00001);
        flush = 1'b0;
        chk("flush_ir", ir_out, 32'hEA000000);
        chk("flush_valid", {31'd0, ir_valid}, 32'd0);
        chk("flush_family", {16'd0, family_bits}, 32'd0);
        chk("flush_cond", {31'd0, COND}, 32'd0);
        load(32'hE3A00001);
        chk("reload_valid", {31'd0, ir_valid}, 32'd1);
        chk("reload_family", {16'd0, family_bits}, 32'h0040);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
